// File: rtl/adj_delay_pkg.sv
// Shared constants and helpers for the adjustable multi-channel delay line.
// Holds the address-width function, the DELAY port width and the delay clamp.
package adj_delay_pkg;

  localparam int unsigned DELAY_W = 16;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    longint unsigned p;
    r = 0;
    p = 1;
    while (p < longint'(v)) begin
      p = p * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // Result is one bit wider than DELAY so that a MAX_DELAY of 65536 is representable.
  function automatic logic [DELAY_W:0] clamp_delay(input logic [DELAY_W-1:0] d,
                                                   input int unsigned max_d);
    logic [DELAY_W:0] m;
    m = (DELAY_W+1)'(max_d);
    if (d == '0)
      return (DELAY_W+1)'(1);
    else if ({1'b0, d} > m)
      return m;
    else
      return {1'b0, d};
  endfunction

  function automatic logic delay_out_of_range(input logic [DELAY_W-1:0] d,
                                              input int unsigned max_d);
    return (d == '0) || ({1'b0, d} > (DELAY_W+1)'(max_d));
  endfunction

endpackage

// File: rtl/dly_sdp_ram.sv
// Simple dual-port RAM with registered read-first output, block-RAM inferable.
// The output register carries a synchronous reset so the delay line can clear its output.
module dly_sdp_ram #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
  end

  // Non-blocking read of the same edge returns the old word when addresses coincide.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_rdata <= '0;
    else if (i_re)
      r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/multi_adj_delay.sv
// Multi-channel delay line with a run-time delay of 1..MAX_DELAY CE samples.
// Pointer, fill accounting, delay clamp and output-valid logic around one shared RAM.
module multi_adj_delay
  import adj_delay_pkg::*;
#(
  parameter int unsigned MAX_DELAY = 1024,
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned CHANNELS  = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      CE,
  input  logic [DELAY_W-1:0]        DELAY,
  input  logic [CHANNELS*WIDTH-1:0] DIN,
  output logic [CHANNELS*WIDTH-1:0] DOUT,
  output logic                      DOUT_VALID,
  output logic                      DELAY_ERR
);

  localparam int unsigned AW = clog2(MAX_DELAY);
  localparam int unsigned DW = CHANNELS * WIDTH;
  localparam logic [AW:0] FILL_MAX = (AW+1)'(MAX_DELAY);

  logic [AW:0]   r_delay_q;
  logic [AW:0]   r_fill;
  logic [AW-1:0] r_wp;
  logic          r_valid;
  logic          r_err;
  logic          w_ce;
  logic [AW-1:0] w_raddr;

  assign w_ce = CE & ~RST;
  // delay_q == MAX_DELAY has zero low bits, so the read address equals wp (oldest word).
  assign w_raddr = r_wp - r_delay_q[AW-1:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_delay_q <= (AW+1)'(1);
      r_err     <= 1'b0;
      r_wp      <= '0;
      r_fill    <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_delay_q <= (AW+1)'(clamp_delay(DELAY, MAX_DELAY));
      r_err     <= r_err | delay_out_of_range(DELAY, MAX_DELAY);
      if (CE) begin
        r_wp    <= r_wp + 1'b1;
        r_valid <= (r_fill >= r_delay_q);
        if (r_fill != FILL_MAX)
          r_fill <= r_fill + 1'b1;
      end
    end
  end

  dly_sdp_ram #(
    .DW    (DW),
    .DEPTH (MAX_DELAY),
    .AW    (AW)
  ) u_ram (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_we    (w_ce),
    .i_waddr (r_wp),
    .i_wdata (DIN),
    .i_re    (w_ce),
    .i_raddr (w_raddr),
    .o_rdata (DOUT)
  );

  assign DOUT_VALID = r_valid;
  assign DELAY_ERR  = r_err;

endmodule

// File: tb/tb_multi_adj_delay.sv
// Directed bench for multi_adj_delay with MAX_DELAY=16, two 8-bit channels.
// Channel 0 carries sample value s, channel 1 carries s+100.
module tb_multi_adj_delay;

  localparam int unsigned MAXD = 16;
  localparam int unsigned W    = 8;
  localparam int unsigned CH   = 2;

  logic            clk  = 1'b0;
  logic            rst  = 1'b1;
  logic            ce   = 1'b0;
  logic [15:0]     dly  = 16'd1;
  logic [CH*W-1:0] din  = '0;
  logic [CH*W-1:0] dout;
  logic            dv;
  logic            derr;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  multi_adj_delay #(
    .MAX_DELAY (MAXD),
    .WIDTH     (W),
    .CHANNELS  (CH)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .CE         (ce),
    .DELAY      (dly),
    .DIN        (din),
    .DOUT       (dout),
    .DOUT_VALID (dv),
    .DELAY_ERR  (derr)
  );

  task automatic drive(input logic ce_v, input int s);
    @(negedge clk);
    ce  = ce_v;
    din = {8'(s + 100), 8'(s)};
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ce  = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (dout !== 16'h0000) begin n_bad++; $display("FAIL reset_dout got %h want 0000", dout); end
    n_cmp++; if (dv !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", dv); end
    n_cmp++; if (derr !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", derr); end
  endtask

  task automatic test_delay3();
    logic [15:0] exp;
    dly = 16'd3;
    do_reset();
    drive(1'b0, 8'hEE);
    for (int n = 0; n < 12; n++) begin
      drive(1'b1, n);
      n_cmp++; if (dv !== (n >= 3)) begin n_bad++; $display("FAIL d3_valid n=%0d got %b want %b", n, dv, n >= 3); end
      if (n >= 3) begin
        exp = {8'(n - 3 + 100), 8'(n - 3)};
        n_cmp++; if (dout !== exp) begin n_bad++; $display("FAIL d3_dout n=%0d got %h want %h", n, dout, exp); end
      end
    end
  endtask

  task automatic test_delay_max();
    logic [15:0] exp;
    dly = 16'd16;
    do_reset();
    drive(1'b0, 8'hEE);
    for (int n = 0; n < 24; n++) begin
      drive(1'b1, n);
      n_cmp++; if (dv !== (n >= 16)) begin n_bad++; $display("FAIL dmax_valid n=%0d got %b want %b", n, dv, n >= 16); end
      if (n >= 16) begin
        exp = {8'(n - 16 + 100), 8'(n - 16)};
        n_cmp++; if (dout !== exp) begin n_bad++; $display("FAIL dmax_dout n=%0d got %h want %h", n, dout, exp); end
      end
    end
    n_cmp++; if (derr !== 1'b0) begin n_bad++; $display("FAIL dmax_err got %b want 0", derr); end
  endtask

  task automatic test_ce_toggle();
    logic [15:0] exp;
    logic        exp_v;
    int          n;
    dly = 16'd5;
    do_reset();
    drive(1'b0, 8'hEE);
    n     = 0;
    exp_v = 1'b0;
    exp   = '0;
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0) begin
        drive(1'b1, n);
        exp_v = (n >= 5);
        exp   = {8'(n - 5 + 100), 8'(n - 5)};
        n++;
      end else begin
        drive(1'b0, 200);
      end
      n_cmp++; if (dv !== exp_v) begin n_bad++; $display("FAIL cetog_valid i=%0d got %b want %b", i, dv, exp_v); end
      if (exp_v) begin
        n_cmp++; if (dout !== exp) begin n_bad++; $display("FAIL cetog_dout i=%0d got %h want %h", i, dout, exp); end
      end
    end
  endtask

  task automatic test_delay_err();
    logic [15:0] exp;
    dly = 16'd0;
    do_reset();
    n_cmp++; if (derr !== 1'b0) begin n_bad++; $display("FAIL err_in_reset got %b want 0", derr); end
    drive(1'b0, 8'hEE);
    n_cmp++; if (derr !== 1'b1) begin n_bad++; $display("FAIL err_zero got %b want 1", derr); end
    for (int n = 0; n < 6; n++) begin
      drive(1'b1, n);
      n_cmp++; if (dv !== (n >= 1)) begin n_bad++; $display("FAIL err_d1_valid n=%0d got %b want %b", n, dv, n >= 1); end
      if (n >= 1) begin
        exp = {8'(n - 1 + 100), 8'(n - 1)};
        n_cmp++; if (dout !== exp) begin n_bad++; $display("FAIL err_d1_dout n=%0d got %h want %h", n, dout, exp); end
      end
    end
    dly = 16'd40;
    drive(1'b0, 8'hEE);
    n_cmp++; if (derr !== 1'b1) begin n_bad++; $display("FAIL err_big got %b want 1", derr); end
    for (int n = 6; n < 22; n++) begin
      drive(1'b1, n);
      n_cmp++; if (dv !== (n >= 16)) begin n_bad++; $display("FAIL err_d16_valid n=%0d got %b want %b", n, dv, n >= 16); end
      if (n >= 16) begin
        exp = {8'(n - 16 + 100), 8'(n - 16)};
        n_cmp++; if (dout !== exp) begin n_bad++; $display("FAIL err_d16_dout n=%0d got %h want %h", n, dout, exp); end
      end
    end
    dly = 16'd5;
    drive(1'b0, 8'hEE);
    n_cmp++; if (derr !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b want 1", derr); end
    do_reset();
    n_cmp++; if (derr !== 1'b0) begin n_bad++; $display("FAIL err_cleared got %b want 0", derr); end
  endtask

  task automatic test_delay_change();
    logic [15:0] exp;
    dly = 16'd4;
    do_reset();
    drive(1'b0, 8'hEE);
    for (int n = 0; n < 6; n++) begin
      drive(1'b1, n);
      n_cmp++; if (dv !== (n >= 4)) begin n_bad++; $display("FAIL chg_d4_valid n=%0d got %b want %b", n, dv, n >= 4); end
      if (n >= 4) begin
        exp = {8'(n - 4 + 100), 8'(n - 4)};
        n_cmp++; if (dout !== exp) begin n_bad++; $display("FAIL chg_d4_dout n=%0d got %h want %h", n, dout, exp); end
      end
    end
    dly = 16'd8;
    drive(1'b0, 8'hEE);
    for (int n = 6; n < 16; n++) begin
      drive(1'b1, n);
      n_cmp++; if (dv !== (n >= 8)) begin n_bad++; $display("FAIL chg_d8_valid n=%0d got %b want %b", n, dv, n >= 8); end
      if (n >= 8) begin
        exp = {8'(n - 8 + 100), 8'(n - 8)};
        n_cmp++; if (dout !== exp) begin n_bad++; $display("FAIL chg_d8_dout n=%0d got %h want %h", n, dout, exp); end
      end
    end
    dly = 16'd2;
    drive(1'b0, 8'hEE);
    for (int n = 16; n < 20; n++) begin
      drive(1'b1, n);
      exp = {8'(n - 2 + 100), 8'(n - 2)};
      n_cmp++; if (dv !== 1'b1) begin n_bad++; $display("FAIL chg_d2_valid n=%0d got %b want 1", n, dv); end
      n_cmp++; if (dout !== exp) begin n_bad++; $display("FAIL chg_d2_dout n=%0d got %h want %h", n, dout, exp); end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp;
    dly = 16'd3;
    do_reset();
    drive(1'b0, 8'hEE);
    for (int n = 0; n < 8; n++) drive(1'b1, n);
    n_cmp++; if (dv !== 1'b1) begin n_bad++; $display("FAIL mid_pre_valid got %b want 1", dv); end
    @(negedge clk);
    rst = 1'b1;
    ce  = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (dout !== 16'h0000) begin n_bad++; $display("FAIL mid_rst_dout got %h want 0000", dout); end
    n_cmp++; if (dv !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid got %b want 0", dv); end
    @(negedge clk);
    rst = 1'b0;
    ce  = 1'b0;
    drive(1'b0, 8'hEE);
    for (int n = 0; n < 8; n++) begin
      drive(1'b1, 50 + n);
      n_cmp++; if (dv !== (n >= 3)) begin n_bad++; $display("FAIL mid_valid n=%0d got %b want %b", n, dv, n >= 3); end
      if (n >= 3) begin
        exp = {8'(50 + n - 3 + 100), 8'(50 + n - 3)};
        n_cmp++; if (dout !== exp) begin n_bad++; $display("FAIL mid_dout n=%0d got %h want %h", n, dout, exp); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_delay3();
    test_delay_max();
    test_ce_toggle();
    test_delay_err();
    test_delay_change();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_adj_delay.md
MULTI_ADJ_DELAY -- requirements
Module: multi_adj_delay

Interface
REQ-001 SHALL have parameter MAX_DELAY, default 1024: maximum delay in CE samples, power of two, 4..65536.
REQ-002 SHALL have parameter WIDTH, default 12: bits per channel sample.
REQ-003 SHALL have parameter CHANNELS, default 4: independent channels sharing one delay setting.
REQ-004 SHALL have port CLK  in  1  master clock; the block uses one clock, CLK only.
REQ-005 SHALL have port RST  in  1  reset, synchronous to CLK, active-high.
REQ-006 SHALL have port CE  in  1  sample enable; one sample per channel is accepted per CLK edge with CE=1.
REQ-007 SHALL have port DELAY  in  16  requested delay in CE samples, legal range 1..MAX_DELAY.
REQ-008 SHALL have port DIN  in  CHANNELS*WIDTH  input samples; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-009 SHALL have port DOUT  out  CHANNELS*WIDTH  delayed samples, registered, same packing as DIN.
REQ-010 SHALL have port DOUT_VALID  out  1  high when DOUT holds a genuinely delayed input sample.
REQ-011 SHALL have port DELAY_ERR  out  1  sticky flag: an out-of-range DELAY was sampled.

Function
REQ-012 SHALL register DELAY every CLK edge, independent of CE, into delay_q; 0 clamps to 1 and values >MAX_DELAY clamp to MAX_DELAY.
REQ-013 SHALL set DELAY_ERR on the edge that samples a clamped value; it SHALL remain set until RST.
REQ-014 SHALL keep a write pointer wp of log2(MAX_DELAY) bits; it SHALL increment modulo MAX_DELAY on each CE edge only.
REQ-015 On each CE edge the block SHALL write DIN at wp and read address (wp - delay_q) mod MAX_DELAY with read-before-write semantics.
REQ-016 The read result SHALL appear on DOUT at the same edge: after the k-th CE sample (k from 0 after reset), DOUT SHALL equal DIN sample k-delay_q.
REQ-017 For delay_q = MAX_DELAY, the read and write addresses SHALL coincide; DOUT SHALL get the old contents, which is sample k-MAX_DELAY.
REQ-018 SHALL keep a fill counter of accepted samples since reset, saturating at MAX_DELAY.
REQ-019 DOUT_VALID SHALL update only on CE edges, to (fill counter value before increment >= delay_q).
REQ-020 With CE=0, DOUT, DOUT_VALID, wp and the fill counter SHALL hold their values.
REQ-021 A delay change SHALL take effect on the first CE edge after delay_q updates, with no flush.
REQ-022 An increase in delay SHALL drop DOUT_VALID if the fill counter is below the new delay; a decrease SHALL never drop DOUT_VALID.
REQ-023 All channels SHALL use identical addressing; channels SHALL never cross-couple.

Reset
REQ-024 RST SHALL clear DOUT, DOUT_VALID, DELAY_ERR, wp and the fill counter to 0, and set delay_q to 1.
REQ-025 RST SHALL take priority over CE; RAM contents are not cleared, and DOUT_VALID gating hides stale data.
REQ-026 RST asserted mid-stream SHALL restart fill accounting from zero on the next CE edge after RST deasserts.

Structure
REQ-027 Package adj_delay_pkg SHALL hold the address-width function (clog2), DELAY port width (16) and the clamp helper.
REQ-028 Storage SHALL be a sub-module dly_sdp_ram: simple dual-port, width CHANNELS*WIDTH, depth MAX_DELAY, registered read-first output, inferable as block RAM.
REQ-029 The top level SHALL contain only the pointer, fill, clamp and valid logic.

Verification
REQ-030 Bench SHALL cover: MAX_DELAY=16, CHANNELS=2, WIDTH=8, DELAY=3, CE=1, DIN ch0=n, ch1=n+100 -> DOUT ch0=n-3, ch1=n-3+100; DOUT_VALID first high after the 4th CE edge.
REQ-031 Bench SHALL cover: DELAY=16 (=MAX) -> DOUT=n-16, DOUT_VALID first high after the 17th CE edge.
REQ-032 Bench SHALL cover: CE toggling 1,0,1,0 with DELAY=5 -> delay counted in CE samples, DOUT frozen on CE=0 edges.
REQ-033 Bench SHALL cover: DELAY=0, then DELAY=40 -> DELAY_ERR=1 and sticky, behaving as delays 1 and 16 respectively.
REQ-034 Bench SHALL cover: streaming at DELAY=4 then DELAY=8 after 6 samples -> DOUT_VALID low for 2 CE samples, then DOUT=n-8.
REQ-035 Bench SHALL cover: RST pulse mid-stream -> all outputs 0 next edge, DOUT_VALID low until delay_q+1 CE samples have been accepted.
